// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the rPLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } pll_seq_state_t;

    // Width of the shared cycle counter: must hold the largest (param - 1).
    function automatic int unsigned cnt_width(input int unsigned rst_cycles,
                                              input int unsigned lock_timeout,
                                              input int unsigned stable_cycles);
        int unsigned m;
        m = rst_cycles;
        if (lock_timeout > m) m = lock_timeout;
        if (stable_cycles > m) m = stable_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer, resets to zero; used for pll_lock and downstream resets.
module sync_ff2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// rPLL reset sequencer: pulses RESET, waits for lock with bounded retries,
// qualifies lock for a stability window, then releases the system reset.
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter  int RST_CYCLES    = 16,
    parameter  int LOCK_TIMEOUT  = 65536,
    parameter  int STABLE_CYCLES = 1024,
    parameter  int MAX_RETRY     = 3,
    localparam int RETRY_W       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic               clkin,
    input  logic               rst_n,
    input  logic               pll_lock,
    input  logic               restart,
    output logic               pll_reset,
    output logic               sys_rst_n,
    output logic               locked,
    output logic               fail,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int CW = int'(cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

    pll_seq_state_t     state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt, retry_inc;
    logic               lost_nxt;
    logic               lock_s;
    logic               take_fail;
    logic               retry_exhausted;

    sync_ff2 #(.WIDTH(1)) u_lock_sync (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Saturating increment covers the retry-forever case without wrapping.
    assign retry_inc       = (retry_cnt == '1) ? retry_cnt : retry_cnt + RETRY_W'(1);
    assign retry_exhausted = (MAX_RETRY != 0) && (retry_cnt == RETRY_W'(MAX_RETRY));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        lost_nxt  = lock_lost;
        take_fail = 1'b0;

        case (state)
            RST: begin
                if (cnt == CW'(RST_CYCLES - 1)) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s)                               state_nxt = STABLE;
                else if (cnt == CW'(LOCK_TIMEOUT - 1))    take_fail = 1'b1;
            end
            STABLE: begin
                if (!lock_s) begin
                    take_fail = 1'b1;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    state_nxt = RUN;
                    retry_nxt = '0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt = RST;
                    lost_nxt  = 1'b1;
                end
            end
            FAIL:    state_nxt = FAIL;
            default: state_nxt = RST;
        endcase

        if (take_fail) begin
            if (retry_exhausted) begin
                state_nxt = FAIL;
            end else begin
                state_nxt = RST;
                retry_nxt = retry_inc;
            end
        end

        if (restart) begin
            state_nxt = RST;
            retry_nxt = '0;
            lost_nxt  = 1'b0;
        end

        // Counter restarts on every state change; it idles in RUN and FAIL.
        if (restart || (state_nxt != state))  cnt_nxt = '0;
        else if (state == RUN || state == FAIL) cnt_nxt = cnt;
        else                                    cnt_nxt = cnt + CW'(1);
    end

    // Outputs decode the next state so they switch on the same edge as the state.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST;
            cnt       <= '0;
            retry_cnt <= '0;
            lock_lost <= 1'b0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            lock_lost <= lost_nxt;
            pll_reset <= (state_nxt == RST) || (state_nxt == FAIL);
            sys_rst_n <= (state_nxt == RUN);
            locked    <= (state_nxt == RUN);
            fail      <= (state_nxt == FAIL);
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: expected output vectors are queued per edge and compared at negedge.
module tb_pll_reset_seq;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRY     = 2;

    logic       clkin    = 1'b0;
    logic       rst_n    = 1'b0;
    logic       pll_lock = 1'b0;
    logic       restart  = 1'b0;
    logic       pll_reset, sys_rst_n, locked, fail, lock_lost;
    logic [1:0] retry_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    typedef struct {
        string      tag;
        int         at;
        logic [6:0] v;
    } exp_t;

    exp_t sb_q[$];

    pll_reset_seq #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .restart   (restart),
        .pll_reset (pll_reset),
        .sys_rst_n (sys_rst_n),
        .locked    (locked),
        .fail      (fail),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt)
    );

    always #5 clkin = ~clkin;

    // Edge number since rst_n was released.
    always @(posedge clkin or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    wire [6:0] outv = {pll_reset, sys_rst_n, locked, fail, lock_lost, retry_cnt};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] ov(input logic pr, input logic sr, input logic lk,
                                      input logic fl, input logic ll, input logic [1:0] rc);
        return {pr, sr, lk, fl, ll, rc};
    endfunction

    function automatic void push(input string tag, input int at, input logic [6:0] v);
        exp_t e;
        e.tag = tag;
        e.at  = at;
        e.v   = v;
        sb_q.push_back(e);
    endfunction

    always @(negedge clkin) begin
        exp_t e;
        if (rst_n) begin
            while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
                e = sb_q.pop_front();
                if (e.at == cyc) check(e.tag, 32'(outv), 32'(e.v));
                else             check({e.tag, "_missed"}, cyc, e.at);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_reset"}, pll_reset, 1'b1);
        check({tag, "_sys_rst_n"}, sys_rst_n, 1'b0);
        check({tag, "_locked"},    locked,    1'b0);
        check({tag, "_fail"},      fail,      1'b0);
        check({tag, "_lock_lost"}, lock_lost, 1'b0);
        check({tag, "_retry_cnt"}, retry_cnt, 2'd0);
    endtask

    task automatic do_reset(input logic lock_val);
        @(negedge clkin);
        rst_n    = 1'b0;
        pll_lock = lock_val;
        restart  = 1'b0;
        #1;
        check_reset_vals("por");
        repeat (3) @(negedge clkin);
        rst_n = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge clkin);
            guard++;
        end
        if (cyc != n) check("wait_cyc", cyc, n);
    endtask

    task automatic drain(input int budget);
        int guard = 0;
        while (sb_q.size() > 0 && guard < budget) begin
            @(negedge clkin);
            guard++;
        end
        if (sb_q.size() > 0) begin
            check("sb_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, r2, d, e;

        // Lock already high: release at RST_CYCLES + 1 + STABLE_CYCLES.
        do_reset(1'b1);
        push("s1_rst_e1",   1,  ov(1, 0, 0, 0, 0, 2'd0));
        push("s1_rst_e3",   3,  ov(1, 0, 0, 0, 0, 2'd0));
        push("s1_wait_e4",  4,  ov(0, 0, 0, 0, 0, 2'd0));
        push("s1_stab_e12", 12, ov(0, 0, 0, 0, 0, 2'd0));
        push("s1_run_e13",  13, ov(0, 1, 1, 0, 0, 2'd0));
        push("s1_run_e20",  20, ov(0, 1, 1, 0, 0, 2'd0));
        drain(100);

        // Lock never arrives: three attempts then FAIL at (4+32)*3.
        do_reset(1'b0);
        push("s2_wait_e4",    4,   ov(0, 0, 0, 0, 0, 2'd0));
        push("s2_wait_e35",   35,  ov(0, 0, 0, 0, 0, 2'd0));
        push("s2_retry1",     36,  ov(1, 0, 0, 0, 0, 2'd1));
        push("s2_wait2",      40,  ov(0, 0, 0, 0, 0, 2'd1));
        push("s2_retry2",     72,  ov(1, 0, 0, 0, 0, 2'd2));
        push("s2_wait3_e107", 107, ov(0, 0, 0, 0, 0, 2'd2));
        push("s2_fail_e108",  108, ov(1, 0, 0, 1, 0, 2'd2));
        push("s2_fail_e150",  150, ov(1, 0, 0, 1, 0, 2'd2));
        drain(200);

        // Restart out of FAIL with lock high.
        r = 160;
        push("s3_fail_hold", r - 1,  ov(1, 0, 0, 1, 0, 2'd2));
        push("s3_restart",   r,      ov(1, 0, 0, 0, 0, 2'd0));
        push("s3_pre_run",   r + 12, ov(0, 0, 0, 0, 0, 2'd0));
        push("s3_run",       r + 13, ov(0, 1, 1, 0, 0, 2'd0));
        wait_cyc(152);
        pll_lock = 1'b1;
        wait_cyc(r - 1);
        restart = 1'b1;
        wait_cyc(r);
        restart = 1'b0;
        drain(100);

        // One-cycle lock glitch during STABLE counts as a failed attempt.
        r2 = r + 20;
        push("s4_restart",   r2,      ov(1, 0, 0, 0, 0, 2'd0));
        push("s4_stable",    r2 + 8,  ov(0, 0, 0, 0, 0, 2'd0));
        push("s4_glitch",    r2 + 9,  ov(1, 0, 0, 0, 0, 2'd1));
        push("s4_pre_run",   r2 + 21, ov(0, 0, 0, 0, 0, 2'd1));
        push("s4_run",       r2 + 22, ov(0, 1, 1, 0, 0, 2'd0));
        wait_cyc(r2 - 1);
        restart = 1'b1;
        wait_cyc(r2);
        restart = 1'b0;
        wait_cyc(r2 + 6);
        pll_lock = 1'b0;
        wait_cyc(r2 + 7);
        pll_lock = 1'b1;
        drain(100);

        // Lock loss in RUN: sys_rst_n falls 3 edges after the lock fall, lock_lost sticks.
        d = r2 + 30;
        push("s5_run_hold",  d + 1,  ov(0, 1, 1, 0, 0, 2'd0));
        push("s5_lost",      d + 2,  ov(1, 0, 0, 0, 1, 2'd0));
        push("s5_wait",      d + 6,  ov(0, 0, 0, 0, 1, 2'd0));
        push("s5_pre_run",   d + 17, ov(0, 0, 0, 0, 1, 2'd0));
        push("s5_rerun",     d + 18, ov(0, 1, 1, 0, 1, 2'd0));
        push("s5_sticky",    d + 25, ov(0, 1, 1, 0, 1, 2'd0));
        wait_cyc(d - 1);
        pll_lock = 1'b0;
        wait_cyc(d + 7);
        pll_lock = 1'b1;
        drain(100);

        // Restart coincident with lock loss in RUN clears lock_lost.
        e = d + 30;
        push("s6_run_hold",  e + 1, ov(0, 1, 1, 0, 1, 2'd0));
        push("s6_restart",   e + 2, ov(1, 0, 0, 0, 0, 2'd0));
        push("s6_wait",      e + 6, ov(0, 0, 0, 0, 0, 2'd0));
        wait_cyc(e - 1);
        pll_lock = 1'b0;
        wait_cyc(e + 1);
        restart = 1'b1;
        wait_cyc(e + 2);
        restart = 1'b0;
        drain(100);

        // Async reset in WAIT_LOCK takes effect with no clock edge.
        wait_cyc(e + 10);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
